// File: rtl/ddr_tester_pkg.sv
// Shared types and constants for the DDR AXI pattern tester: FSM state encoding,
// AXI burst/response codes and a saturating error-count helper.
package ddr_tester_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_AW,
    WR_W,
    WR_B,
    RD_AR,
    RD_R,
    DONE
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [2:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {14'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/ddr_tester_checker.sv
// Per-beat response/data comparison and saturating error accumulator.
// o_err_next exposes the value err_cnt will take, so the FSM can settle pass on the final beat.
module ddr_tester_checker
  import ddr_tester_pkg::*;
#(
  parameter logic [3:0] TID = 4'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_rd_beat,
  input  logic [31:0] i_rd_data,
  input  logic [31:0] i_rd_exp,
  input  logic [1:0]  i_rd_resp,
  input  logic [3:0]  i_rd_id,
  input  logic        i_rd_last,
  input  logic        i_rd_exp_last,
  input  logic        i_wr_beat,
  input  logic [1:0]  i_wr_resp,
  input  logic [3:0]  i_wr_id,
  output logic [15:0] o_err_cnt,
  output logic [15:0] o_err_next
);

  logic [15:0] r_err_cnt;
  logic [2:0]  w_incr;

  // Each failing condition on a beat contributes one error.
  always_comb begin
    w_incr = 3'd0;
    if (i_rd_beat)
      w_incr = 3'(i_rd_data != i_rd_exp) + 3'(i_rd_resp != AXI_RESP_OKAY)
             + 3'(i_rd_id != TID) + 3'(i_rd_last != i_rd_exp_last);
    else if (i_wr_beat)
      w_incr = 3'(i_wr_resp != AXI_RESP_OKAY) + 3'(i_wr_id != TID);
    o_err_next = i_clr ? 16'd0 : sat_add16(r_err_cnt, w_incr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err_cnt <= 16'd0;
    else     r_err_cnt <= o_err_next;
  end

  assign o_err_cnt = r_err_cnt;

endmodule

// File: rtl/ddr_axi_pattern_tester.sv
// AXI master that writes address-as-data bursts, reads them back and counts mismatches.
// One transaction outstanding at a time; every output comes straight from a register.
module ddr_axi_pattern_tester
  import ddr_tester_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [7:0]  BURST_LEN  = 8'd15,
  parameter logic [15:0] NUM_BURSTS = 16'd64,
  parameter logic [3:0]  TID        = 4'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_cnt,
  output logic [3:0]  MASTER_WR_ADDR_ID,
  output logic [31:0] MASTER_WR_ADDR_ADDR,
  output logic [7:0]  MASTER_WR_ADDR_LEN,
  output logic [1:0]  MASTER_WR_ADDR_BURST,
  output logic        MASTER_WR_ADDR_VALID,
  input  logic        MASTER_WR_ADDR_READY,
  output logic [31:0] MASTER_WR_DATA,
  output logic [3:0]  MASTER_WR_STRB,
  output logic        MASTER_WR_LAST,
  output logic        MASTER_WR_DATA_VALID,
  input  logic        MASTER_WR_DATA_READY,
  input  logic [3:0]  MASTER_WR_BACK_ID,
  input  logic [1:0]  MASTER_WR_BACK_RESP,
  input  logic        MASTER_WR_BACK_VALID,
  output logic        MASTER_WR_BACK_READY,
  output logic [3:0]  MASTER_RD_ADDR_ID,
  output logic [31:0] MASTER_RD_ADDR_ADDR,
  output logic [7:0]  MASTER_RD_ADDR_LEN,
  output logic [1:0]  MASTER_RD_ADDR_BURST,
  output logic        MASTER_RD_ADDR_VALID,
  input  logic        MASTER_RD_ADDR_READY,
  input  logic [3:0]  MASTER_RD_BACK_ID,
  input  logic [31:0] MASTER_RD_BACK_DATA,
  input  logic [1:0]  MASTER_RD_BACK_RESP,
  input  logic        MASTER_RD_BACK_LAST,
  input  logic        MASTER_RD_BACK_VALID,
  output logic        MASTER_RD_DATA_READY
);

  localparam logic [31:0] STRIDE = ({24'd0, BURST_LEN} + 32'd1) << 2;
  localparam logic [15:0] LAST_K = NUM_BURSTS - 16'd1;

  state_t      r_state, w_state_next;
  logic [15:0] r_k, w_k_next;
  logic [7:0]  r_j, w_j_next;
  logic [31:0] r_addr, w_addr_next;
  logic [31:0] r_wdata, w_wdata_next;
  logic [31:0] r_rexp, w_rexp_next;
  logic        r_awvalid, w_awvalid_next;
  logic        r_wvalid, w_wvalid_next;
  logic        r_wlast, w_wlast_next;
  logic        r_bready, w_bready_next;
  logic        r_arvalid, w_arvalid_next;
  logic        r_rready, w_rready_next;
  logic        r_busy, w_busy_next;
  logic        r_done, w_done_next;
  logic        r_pass, w_pass_next;
  logic        r_cfg_en, w_cfg_en_next;
  logic        w_clr, w_rd_beat, w_wr_beat;
  logic [15:0] w_err_cnt, w_err_next;

  always_comb begin
    w_state_next   = r_state;
    w_k_next       = r_k;
    w_j_next       = r_j;
    w_addr_next    = r_addr;
    w_wdata_next   = r_wdata;
    w_rexp_next    = r_rexp;
    w_awvalid_next = r_awvalid;
    w_wvalid_next  = r_wvalid;
    w_wlast_next   = r_wlast;
    w_bready_next  = r_bready;
    w_arvalid_next = r_arvalid;
    w_rready_next  = r_rready;
    w_busy_next    = r_busy;
    w_done_next    = r_done;
    w_pass_next    = r_pass;
    w_cfg_en_next  = r_cfg_en;
    w_clr          = 1'b0;
    w_rd_beat      = 1'b0;
    w_wr_beat      = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_clr          = 1'b1;
          w_state_next   = WR_AW;
          w_awvalid_next = 1'b1;
          w_addr_next    = BASE_ADDR;
          w_k_next       = 16'd0;
          w_j_next       = 8'd0;
          w_busy_next    = 1'b1;
          w_done_next    = 1'b0;
          w_pass_next    = 1'b0;
          w_cfg_en_next  = 1'b1;
        end
      end
      WR_AW: begin
        if (MASTER_WR_ADDR_READY) begin
          w_awvalid_next = 1'b0;
          w_wvalid_next  = 1'b1;
          w_wdata_next   = r_addr;
          w_wlast_next   = (BURST_LEN == 8'd0);
          w_j_next       = 8'd0;
          w_state_next   = WR_W;
        end
      end
      WR_W: begin
        if (MASTER_WR_DATA_READY) begin
          if (r_wlast) begin
            w_wvalid_next = 1'b0;
            w_wlast_next  = 1'b0;
            w_bready_next = 1'b1;
            w_state_next  = WR_B;
          end else begin
            w_j_next     = r_j + 8'd1;
            w_wdata_next = r_wdata + 32'd4;
            w_wlast_next = ((r_j + 8'd1) == BURST_LEN);
          end
        end
      end
      WR_B: begin
        if (MASTER_WR_BACK_VALID) begin
          w_wr_beat     = 1'b1;
          w_bready_next = 1'b0;
          if (r_k == LAST_K) begin
            w_k_next       = 16'd0;
            w_addr_next    = BASE_ADDR;
            w_arvalid_next = 1'b1;
            w_state_next   = RD_AR;
          end else begin
            w_k_next       = r_k + 16'd1;
            w_addr_next    = r_addr + STRIDE;
            w_awvalid_next = 1'b1;
            w_state_next   = WR_AW;
          end
        end
      end
      RD_AR: begin
        if (MASTER_RD_ADDR_READY) begin
          w_arvalid_next = 1'b0;
          w_rready_next  = 1'b1;
          w_rexp_next    = r_addr;
          w_j_next       = 8'd0;
          w_state_next   = RD_R;
        end
      end
      RD_R: begin
        if (MASTER_RD_BACK_VALID) begin
          w_rd_beat = 1'b1;
          // A short burst (early LAST) ends here too; missing beats are not waited for.
          if (MASTER_RD_BACK_LAST || r_j == BURST_LEN) begin
            w_rready_next = 1'b0;
            w_j_next      = 8'd0;
            if (r_k == LAST_K) begin
              w_k_next     = 16'd0;
              w_busy_next  = 1'b0;
              w_done_next  = 1'b1;
              w_pass_next  = (w_err_next == 16'd0);
              w_state_next = DONE;
            end else begin
              w_k_next       = r_k + 16'd1;
              w_addr_next    = r_addr + STRIDE;
              w_arvalid_next = 1'b1;
              w_state_next   = RD_AR;
            end
          end else begin
            w_j_next    = r_j + 8'd1;
            w_rexp_next = r_rexp + 32'd4;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_k       <= 16'd0;
      r_j       <= 8'd0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_rexp    <= 32'd0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_wlast   <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_cfg_en  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_k       <= w_k_next;
      r_j       <= w_j_next;
      r_addr    <= w_addr_next;
      r_wdata   <= w_wdata_next;
      r_rexp    <= w_rexp_next;
      r_awvalid <= w_awvalid_next;
      r_wvalid  <= w_wvalid_next;
      r_wlast   <= w_wlast_next;
      r_bready  <= w_bready_next;
      r_arvalid <= w_arvalid_next;
      r_rready  <= w_rready_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
      r_pass    <= w_pass_next;
      r_cfg_en  <= w_cfg_en_next;
    end
  end

  ddr_tester_checker #(.TID(TID)) u_checker (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (w_clr),
    .i_rd_beat    (w_rd_beat),
    .i_rd_data    (MASTER_RD_BACK_DATA),
    .i_rd_exp     (r_rexp),
    .i_rd_resp    (MASTER_RD_BACK_RESP),
    .i_rd_id      (MASTER_RD_BACK_ID),
    .i_rd_last    (MASTER_RD_BACK_LAST),
    .i_rd_exp_last(r_j == BURST_LEN),
    .i_wr_beat    (w_wr_beat),
    .i_wr_resp    (MASTER_WR_BACK_RESP),
    .i_wr_id      (MASTER_WR_BACK_ID),
    .o_err_cnt    (w_err_cnt),
    .o_err_next   (w_err_next)
  );

  // Fixed channel fields read as zero until the first run after reset.
  assign MASTER_WR_ADDR_ID    = r_cfg_en ? TID : 4'h0;
  assign MASTER_WR_ADDR_LEN   = r_cfg_en ? BURST_LEN : 8'h0;
  assign MASTER_WR_ADDR_BURST = r_cfg_en ? AXI_BURST_INCR : 2'b00;
  assign MASTER_WR_ADDR_ADDR  = r_addr;
  assign MASTER_WR_ADDR_VALID = r_awvalid;
  assign MASTER_WR_DATA       = r_wdata;
  assign MASTER_WR_STRB       = r_cfg_en ? 4'hF : 4'h0;
  assign MASTER_WR_LAST       = r_wlast;
  assign MASTER_WR_DATA_VALID = r_wvalid;
  assign MASTER_WR_BACK_READY = r_bready;
  assign MASTER_RD_ADDR_ID    = r_cfg_en ? TID : 4'h0;
  assign MASTER_RD_ADDR_LEN   = r_cfg_en ? BURST_LEN : 8'h0;
  assign MASTER_RD_ADDR_BURST = r_cfg_en ? AXI_BURST_INCR : 2'b00;
  assign MASTER_RD_ADDR_ADDR  = r_addr;
  assign MASTER_RD_ADDR_VALID = r_arvalid;
  assign MASTER_RD_DATA_READY = r_rready;
  assign busy                 = r_busy;
  assign done                 = r_done;
  assign pass                 = r_pass;
  assign err_cnt              = w_err_cnt;

endmodule
